// File: rtl/viterbi_pkg.sv
// Shared definitions for the 4-state, K=3, rate-1/2 Viterbi ACS controller:
// trellis size, default metric width, controller FSM states, branch-label
// lookup and predecessor mapping.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int PM_W_DEF   = 7;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Branch labels, packed s3..s0, two bits per state.
    // pred1 labels: s0=00 s1=10 s2=11 s3=01
    // pred2 labels: s0=11 s1=01 s2=00 s3=10
    localparam logic [7:0] LABEL_P1_TBL = {2'b01, 2'b11, 2'b10, 2'b00};
    localparam logic [7:0] LABEL_P2_TBL = {2'b10, 2'b00, 2'b01, 2'b11};

    // Code label on the branch into state s from pred1 (sel=0) or pred2 (sel=1)
    function automatic logic [1:0] branch_label(input logic [1:0] s, input logic sel);
        logic [7:0] tbl;
        tbl = sel ? LABEL_P2_TBL : LABEL_P1_TBL;
        return tbl[2*s +: 2];
    endfunction

    // Predecessor of state s: pred1={s[0],0}, pred2={s[0],1}
    function automatic logic [1:0] pred_of(input logic [1:0] s, input logic sel);
        return {s[0], sel};
    endfunction

endpackage

// File: rtl/acs_decide.sv
// Combinational add-compare-select for one trellis state.
// Candidates are formed at PM_W+1 bits; a tie keeps pred1 (decision 0).
// Optional feature macro: ACS_NORM_EN. When it is undefined the candidates
// saturate at 2^PM_W-1 before the compare, since no normalization keeps them
// in range; when defined, the scheduler's normalization guarantees no wrap.
module acs_decide
    import viterbi_pkg::*;
#(
    parameter int PM_W = PM_W_DEF
) (
    input  logic [1:0]      i_sym_data,
    input  logic [1:0]      i_state,
    input  logic [PM_W-1:0] i_pm1,
    input  logic [PM_W-1:0] i_pm2,
    output logic [PM_W-1:0] o_pm,
    output logic            o_dec
);

    localparam int CW = PM_W + 1;

    logic [1:0]    w_x1;
    logic [1:0]    w_x2;
    logic [1:0]    w_bm1;
    logic [1:0]    w_bm2;
    logic [CW-1:0] w_c1;
    logic [CW-1:0] w_c2;
    logic [CW-1:0] w_s1;
    logic [CW-1:0] w_s2;

    // Hamming branch metrics, candidate sums, optional saturation and select
    always_comb begin
        w_x1  = i_sym_data ^ branch_label(i_state, 1'b0);
        w_x2  = i_sym_data ^ branch_label(i_state, 1'b1);
        w_bm1 = {1'b0, w_x1[0]} + {1'b0, w_x1[1]};
        w_bm2 = {1'b0, w_x2[0]} + {1'b0, w_x2[1]};
        w_c1  = {1'b0, i_pm1} + {{(CW-2){1'b0}}, w_bm1};
        w_c2  = {1'b0, i_pm2} + {{(CW-2){1'b0}}, w_bm2};
`ifdef ACS_NORM_EN
        w_s1  = w_c1;
        w_s2  = w_c2;
`else
        w_s1  = (w_c1 > {1'b0, {PM_W{1'b1}}}) ? {1'b0, {PM_W{1'b1}}} : w_c1;
        w_s2  = (w_c2 > {1'b0, {PM_W{1'b1}}}) ? {1'b0, {PM_W{1'b1}}} : w_c2;
`endif
        o_dec = (w_s1 > w_s2);
        o_pm  = o_dec ? w_s2[PM_W-1:0] : w_s1[PM_W-1:0];
    end

endmodule

// File: rtl/acs_scheduler.sv
// Time-multiplexed ACS controller for the 4-state Viterbi decoder.
// One symbol per trellis step; the shared acs_decide is swept over the four
// states in RUN, one per cycle, then the decision word is offered on a
// valid/ready port.
// Optional feature macro: ACS_NORM_EN (metric normalization by 2^(PM_W-1)).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. sym_ready is high only in IDLE; dec_valid is high only in DONE
// and the decision outputs are held stable until dec_ready accepts them.
module acs_scheduler
    import viterbi_pkg::*;
#(
    parameter int PM_W    = PM_W_DEF,
    parameter int INIT_PM = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic [1:0]                 sym_data,
    input  logic                       frame_start,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [3:0]                 dec_bits,
    output logic [1:0]                 dec_best_state,
    output logic [PM_W-1:0]            pm_min,
    output logic [1:0]                 o_dbg_state,
    output logic [NUM_STATES*PM_W-1:0] o_dbg_pm
);

    localparam logic [PM_W-1:0] INIT_V = INIT_PM[PM_W-1:0];
`ifdef ACS_NORM_EN
    localparam logic [PM_W-1:0] HALF_V = {1'b1, {(PM_W-1){1'b0}}};
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_cnt;
    logic [1:0]      r_sym;
    logic [PM_W-1:0] r_cur [NUM_STATES];
    logic [PM_W-1:0] r_nxt [NUM_STATES];
    logic [3:0]      r_dec_bits;
    logic [1:0]      r_best;
    logic [PM_W-1:0] r_pm_min;

    logic            w_sym_ready;
    logic            w_dec_valid;
    logic [PM_W-1:0] w_acs_pm;
    logic            w_acs_dec;
    logic [PM_W-1:0] w_new [NUM_STATES];
    logic [PM_W-1:0] w_min;
    logic [1:0]      w_best;
    logic [PM_W-1:0] w_sub;

    // Shared ACS datapath, addressed by the state counter; reads only from cur
    acs_decide #(.PM_W(PM_W)) u_acs (
        .i_sym_data (r_sym),
        .i_state    (r_cnt),
        .i_pm1      (r_cur[pred_of(r_cnt, 1'b0)]),
        .i_pm2      (r_cur[pred_of(r_cnt, 1'b1)]),
        .o_pm       (w_acs_pm),
        .o_dec      (w_acs_dec)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_sym_ready = 1'b0;
        w_dec_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sym_ready = 1'b1;
                if (sym_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == 2'd3) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_dec_valid = 1'b1;
                if (dec_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // New-metric view for the final RUN cycle: state 3 comes straight from the ACS
    always_comb begin
        for (int i = 0; i < NUM_STATES; i++) w_new[i] = r_nxt[i];
        w_new[NUM_STATES-1] = w_acs_pm;
        w_min  = w_new[0];
        w_best = 2'd0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (w_new[i] < w_min) begin
                w_min  = w_new[i];
                w_best = 2'(i);
            end
        end
`ifdef ACS_NORM_EN
        w_sub = (w_min >= HALF_V) ? HALF_V : '0;
`else
        w_sub = '0;
`endif
    end

    // Metric banks, counter, symbol latch and decision registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 2'd0;
            r_sym      <= 2'd0;
            r_dec_bits <= 4'd0;
            r_best     <= 2'd0;
            r_pm_min   <= '0;
            for (int i = 0; i < NUM_STATES; i++) begin
                r_cur[i] <= (i == 0) ? '0 : INIT_V;
                r_nxt[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sym_valid) begin
                        r_sym <= sym_data;
                        r_cnt <= 2'd0;
                        if (frame_start) begin
                            for (int i = 0; i < NUM_STATES; i++)
                                r_cur[i] <= (i == 0) ? '0 : INIT_V;
                        end
                    end
                end
                ST_RUN: begin
                    r_nxt[r_cnt]      <= w_acs_pm;
                    r_dec_bits[r_cnt] <= w_acs_dec;
                    r_cnt             <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        for (int i = 0; i < NUM_STATES; i++)
                            r_cur[i] <= w_new[i] - w_sub;
                        r_pm_min <= w_min - w_sub;
                        r_best   <= w_best;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and debug mapping
    always_comb begin
        sym_ready      = w_sym_ready;
        dec_valid      = w_dec_valid;
        dec_bits       = r_dec_bits;
        dec_best_state = r_best;
        pm_min         = r_pm_min;
        o_dbg_state    = r_state;
        for (int i = 0; i < NUM_STATES; i++) o_dbg_pm[i*PM_W +: PM_W] = r_cur[i];
    end

endmodule

// File: tb/tb_acs_scheduler.sv
// Bench for acs_scheduler: random symbol streams checked against a
// trellis-level reference model, with handshake stalls and mid-step reset.
module tb_acs_scheduler;
    import viterbi_pkg::*;

    localparam int PM_W   = 7;
    localparam int INIT   = 32;
    localparam int PM_MAX = (1 << PM_W) - 1;
    localparam int HALF   = 1 << (PM_W - 1);
    localparam int W      = 4 + 2 + PM_W + 4 * PM_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              sym_valid;
    logic              sym_ready;
    logic [1:0]        sym_data;
    logic              frame_start;
    logic              dec_valid;
    logic              dec_ready;
    logic [3:0]        dec_bits;
    logic [1:0]        dec_best_state;
    logic [PM_W-1:0]   pm_min;
    logic [1:0]        dbg_state;
    logic [4*PM_W-1:0] dbg_pm;

    int n_vec = 0;
    int n_err = 0;
    int cur_m [4];
    logic [W-1:0] exp_q [$];

    // clock / reset
    always #5 clk = ~clk;

    acs_scheduler #(.PM_W(PM_W), .INIT_PM(INIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .sym_valid      (sym_valid),
        .sym_ready      (sym_ready),
        .sym_data       (sym_data),
        .frame_start    (frame_start),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_bits       (dec_bits),
        .dec_best_state (dec_best_state),
        .pm_min         (pm_min),
        .o_dbg_state    (dbg_state),
        .o_dbg_pm       (dbg_pm)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*PM_W-1:0] pack_bank();
        logic [4*PM_W-1:0] b;
        for (int i = 0; i < 4; i++) b[i*PM_W +: PM_W] = PM_W'(cur_m[i]);
        return b;
    endfunction

    task automatic model_init();
        cur_m[0] = 0;
        for (int i = 1; i < 4; i++) cur_m[i] = INIT;
    endtask

    // Reference: one trellis step from the stated predecessor/label rules
    task automatic model_step(input int sym, input bit fs);
        int lab1 [4];
        int lab2 [4];
        int nw [4];
        int c1, c2, mn, best;
        logic [3:0] bits;
        lab1 = '{0, 2, 3, 1};
        lab2 = '{3, 1, 0, 2};
        if (fs) model_init();
        for (int s = 0; s < 4; s++) begin
            c1 = cur_m[2 * (s % 2)]     + $countones(2'(sym ^ lab1[s]));
            c2 = cur_m[2 * (s % 2) + 1] + $countones(2'(sym ^ lab2[s]));
`ifndef ACS_NORM_EN
            if (c1 > PM_MAX) c1 = PM_MAX;
            if (c2 > PM_MAX) c2 = PM_MAX;
`endif
            bits[s] = (c1 > c2);
            nw[s]   = (c1 > c2) ? c2 : c1;
        end
        mn = nw[0]; best = 0;
        for (int s = 1; s < 4; s++) if (nw[s] < mn) begin mn = nw[s]; best = s; end
`ifdef ACS_NORM_EN
        if (mn >= HALF) begin
            mn = mn - HALF;
            for (int s = 0; s < 4; s++) nw[s] = nw[s] - HALF;
        end
`endif
        for (int s = 0; s < 4; s++) cur_m[s] = nw[s];
        exp_q.push_back({bits, 2'(best), PM_W'(mn), pack_bank()});
    endtask

    // Driver: one symbol, then collect and check its decision word.
    // hold>0 keeps dec_ready low for that many cycles after dec_valid.
    task automatic do_step(input logic [1:0] sym, input logic fs, input int hold);
        int n;
        logic [W-1:0] e;
        logic [3:0] db; logic [1:0] bs; logic [PM_W-1:0] pm;
        n = 0;
        while (!sym_ready && n < 20) begin @(negedge clk); n++; end
        chk("sym_ready_idle", sym_ready, 1);
        sym_valid = 1; sym_data = sym; frame_start = fs; dec_ready = (hold == 0);
        @(negedge clk);
        sym_valid = 0; frame_start = 0; sym_data = 2'($urandom_range(0, 3));
        model_step(int'(sym), fs);
        n = 1;
        while (!dec_valid && n < 12) begin @(negedge clk); n++; end
        chk("latency", n, 5);
        e = exp_q.pop_front();
        chk("dec_bits", dec_bits, e[W-1 -: 4]);
        chk("best_state", dec_best_state, e[W-5 -: 2]);
        chk("pm_min", pm_min, e[4*PM_W +: PM_W]);
        chk("bank", dbg_pm, e[4*PM_W-1:0]);
        db = dec_bits; bs = dec_best_state; pm = pm_min;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                sym_valid = (k == 3);
                @(negedge clk);
                chk("hold_valid", dec_valid, 1);
                chk("hold_sym_ready", sym_ready, 0);
                chk("hold_stable", {db, bs, pm}, {dec_bits, dec_best_state, pm_min});
            end
            sym_valid = 0;
            dec_ready = 1;
        end
        @(negedge clk);
        chk("release_idle", dbg_state, ST_IDLE);
        chk("release_valid", dec_valid, 0);
    endtask

    initial begin
        rst = 1; sym_valid = 0; sym_data = 0; frame_start = 0; dec_ready = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        model_init();
        chk("rst_sym_ready", sym_ready, 1);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_pm_min", pm_min, 0);
        chk("rst_dec_bits", dec_bits, 0);
        chk("rst_best", dec_best_state, 0);
        chk("rst_bank", dbg_pm, pack_bank());
        chk("rst_state", dbg_state, ST_IDLE);

        // frame start with 00 then 11
        do_step(2'b00, 1'b1, 0);
        chk("bank_after_00", dbg_pm, {7'd33, 7'd2, 7'd33, 7'd0});
        do_step(2'b11, 1'b0, 0);
        chk("bank_after_11", dbg_pm, {7'd3, 7'd0, 7'd3, 7'd2});

        // stalled consumer with an ignored symbol pulse
        do_step(2'($urandom_range(0, 3)), 1'b0, 10);
        do_step(2'($urandom_range(0, 3)), 1'b0, 0);

        // frame_start without sym_valid must not reload the bank
        frame_start = 1; @(negedge clk); frame_start = 0;
        do_step(2'($urandom_range(0, 3)), 1'b0, 0);

        // reset in RUN at cnt=2
        sym_valid = 1; sym_data = 2'b01; frame_start = 0;
        @(negedge clk); sym_valid = 0;
        repeat (2) @(negedge clk);
        chk("abort_in_run", dbg_state, ST_RUN);
        rst = 1; @(negedge clk); rst = 0;
        model_init();
        chk("abort_state", dbg_state, ST_IDLE);
        chk("abort_valid", dec_valid, 0);
        chk("abort_bank", dbg_pm, pack_bank());
        do_step(2'b00, 1'b1, 0);
        do_step(2'b11, 1'b0, 0);

        // rising floor: long stream of 01 after a frame start
        do_step(2'b01, 1'b1, 0);
        for (int i = 0; i < 400; i++) do_step(2'b01, 1'b0, 0);

        // random traffic with occasional frame starts and stalls
        for (int i = 0; i < 80; i++)
            do_step(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
